// File: rtl/ac97_cmd_sched.sv
// ac97_cmd_sched: round-robin, frame-synchronous AC-link register command scheduler for two requesters.
// Define AC97_CMD_INIT_EN to issue a fixed three-write codec setup sequence after reset.
module ac97_cmd_sched #(
    parameter int TIMEOUT_FRAMES = 4
) (
    input  logic        ac97_bitclk,
    input  logic        ac97_rst_b,
    input  logic        ac97_strobe,
    input  logic [15:0] ac97_in_tag,
    input  logic [19:0] ac97_in_slot1,
    input  logic [19:0] ac97_in_slot2,
    output logic [19:0] ac97_out_slot1,
    output logic        ac97_out_slot1_valid,
    output logic [19:0] ac97_out_slot2,
    output logic        ac97_out_slot2_valid,
    input  logic        req0,
    input  logic        we0,
    input  logic [6:0]  addr0,
    input  logic [15:0] wdata0,
    output logic        done0,
    output logic [15:0] rdata0,
    output logic        err0,
    input  logic        req1,
    input  logic        we1,
    input  logic [6:0]  addr1,
    input  logic [15:0] wdata1,
    output logic        done1,
    output logic [15:0] rdata1,
    output logic        err1
);
`ifdef AC97_CMD_INIT_EN
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_INIT} state_t;
    localparam state_t RST_STATE = S_INIT;
    logic [2:0]  r_init_step, w_init_step;
    logic [6:0]  w_init_addr;
    logic [15:0] w_init_data;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD} state_t;
    localparam state_t RST_STATE = S_IDLE;
`endif
    state_t      r_state, w_state;
    logic        r_ptr, w_ptr, r_sel, w_sel, r_we, w_we;
    logic [6:0]  r_addr, w_addr;
    logic [7:0]  r_cnt, w_cnt, w_cnt_inc;
    logic [19:0] r_slot1, w_slot1, r_slot2, w_slot2;
    logic        r_slot1_v, w_slot1_v, r_slot2_v, w_slot2_v;
    logic [1:0]  r_done, w_done, r_err, w_err;
    logic [15:0] r_rdata0, w_rdata0, r_rdata1, w_rdata1, w_rd_val;
    logic        w_gnt, w_gnt_we, w_match;
    logic [6:0]  w_gnt_addr;
    logic [15:0] w_gnt_wdata;
    logic        w_unused;

    assign w_unused = ^{ac97_in_tag[15], ac97_in_tag[12:0], ac97_in_slot1[19], ac97_in_slot1[11:0], ac97_in_slot2[3:0]};
    // Favour r_ptr only when both request; a lone requester always wins.
    assign w_gnt       = req0 ? (req1 & r_ptr) : 1'b1;
    assign w_gnt_we    = w_gnt ? we1 : we0;
    assign w_gnt_addr  = w_gnt ? addr1 : addr0;
    assign w_gnt_wdata = w_gnt ? wdata1 : wdata0;
    assign w_match     = ac97_in_tag[14] & ac97_in_tag[13] & (ac97_in_slot1[18:12] == r_addr);
    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_rd_val    = w_match ? ac97_in_slot2[19:4] : 16'hFFFF;
`ifdef AC97_CMD_INIT_EN
    assign w_init_addr = (r_init_step[2:1] == 2'd0) ? 7'h00 : (r_init_step[2:1] == 2'd1) ? 7'h02 : 7'h18;
    assign w_init_data = (r_init_step[2:1] == 2'd2) ? 16'h0808 : 16'h0000;
`endif

    always_comb begin
        w_state   = r_state;
        w_ptr     = r_ptr;
        w_sel     = r_sel;
        w_we      = r_we;
        w_addr    = r_addr;
        w_cnt     = r_cnt;
        w_slot1   = r_slot1;
        w_slot1_v = r_slot1_v;
        w_slot2   = r_slot2;
        w_slot2_v = r_slot2_v;
        w_done    = 2'b00;
        w_err     = r_err;
        w_rdata0  = r_rdata0;
        w_rdata1  = r_rdata1;
`ifdef AC97_CMD_INIT_EN
        w_init_step = r_init_step;
`endif
        if (ac97_strobe) begin
            w_slot1   = 20'h0;
            w_slot1_v = 1'b0;
            w_slot2   = 20'h0;
            w_slot2_v = 1'b0;
            case (r_state)
                S_IDLE: if (req0 | req1) begin
                    w_sel     = w_gnt;
                    w_ptr     = ~w_gnt;
                    w_we      = w_gnt_we;
                    w_addr    = w_gnt_addr;
                    w_slot1   = {~w_gnt_we, w_gnt_addr, 12'h000};
                    w_slot1_v = 1'b1;
                    w_slot2   = w_gnt_we ? {w_gnt_wdata, 4'h0} : 20'h0;
                    w_slot2_v = w_gnt_we;
                    w_state   = S_ISSUE;
                end
                S_ISSUE: if (r_we) begin
                    w_done[r_sel] = 1'b1;
                    w_err[r_sel]  = 1'b0;
                    w_state       = S_IDLE;
                end else begin
                    w_cnt   = 8'd0;
                    w_state = S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    w_cnt = w_cnt_inc;
                    if (w_match || w_cnt_inc == 8'(TIMEOUT_FRAMES)) begin
                        w_done[r_sel] = 1'b1;
                        w_err[r_sel]  = ~w_match;
                        w_rdata0      = r_sel ? r_rdata0 : w_rd_val;
                        w_rdata1      = r_sel ? w_rd_val : r_rdata1;
                        w_state       = S_IDLE;
                    end
                end
`ifdef AC97_CMD_INIT_EN
                // Even steps put a setup write on the wire, odd steps are the idle gap.
                S_INIT: begin
                    w_init_step = r_init_step + 3'd1;
                    if (!r_init_step[0]) begin
                        w_slot1   = {1'b0, w_init_addr, 12'h000};
                        w_slot1_v = 1'b1;
                        w_slot2   = {w_init_data, 4'h0};
                        w_slot2_v = 1'b1;
                    end
                    if (r_init_step == 3'd5) w_state = S_IDLE;
                end
`endif
                default: w_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge ac97_bitclk or negedge ac97_rst_b) begin
        if (!ac97_rst_b) begin
            r_state   <= RST_STATE;
            r_ptr     <= 1'b0;
            r_sel     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 7'h0;
            r_cnt     <= 8'h0;
            r_slot1   <= 20'h0;
            r_slot1_v <= 1'b0;
            r_slot2   <= 20'h0;
            r_slot2_v <= 1'b0;
            r_done    <= 2'b00;
            r_err     <= 2'b00;
            r_rdata0  <= 16'h0;
            r_rdata1  <= 16'h0;
`ifdef AC97_CMD_INIT_EN
            r_init_step <= 3'd0;
`endif
        end else begin
            r_state   <= w_state;
            r_ptr     <= w_ptr;
            r_sel     <= w_sel;
            r_we      <= w_we;
            r_addr    <= w_addr;
            r_cnt     <= w_cnt;
            r_slot1   <= w_slot1;
            r_slot1_v <= w_slot1_v;
            r_slot2   <= w_slot2;
            r_slot2_v <= w_slot2_v;
            r_done    <= w_done;
            r_err     <= w_err;
            r_rdata0  <= w_rdata0;
            r_rdata1  <= w_rdata1;
`ifdef AC97_CMD_INIT_EN
            r_init_step <= w_init_step;
`endif
        end
    end

    assign ac97_out_slot1       = r_slot1;
    assign ac97_out_slot1_valid = r_slot1_v;
    assign ac97_out_slot2       = r_slot2;
    assign ac97_out_slot2_valid = r_slot2_v;
    assign done0  = r_done[0];
    assign done1  = r_done[1];
    assign err0   = r_err[0];
    assign err1   = r_err[1];
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;
endmodule

// File: tb/tb_ac97_cmd_sched.sv
// tb_ac97_cmd_sched: scoreboard bench for ac97_cmd_sched in its default build (AC97_CMD_INIT_EN undefined).
module tb_ac97_cmd_sched;
    localparam int FR = 16;

    typedef struct {
        bit          id;
        logic [15:0] rd;
        bit          err;
        bit          chk_rd;
        int          fr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        strobe = 1'b0;
    logic [15:0] in_tag = '0;
    logic [19:0] in_slot1 = '0, in_slot2 = '0;
    logic [19:0] out_slot1, out_slot2;
    logic        out_slot1_v, out_slot2_v;
    logic        req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [6:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        done0, done1, err0, err1;
    logic [15:0] rdata0, rdata1;
    int          checks = 0, errors = 0, fcnt = 0;
    exp_t        q[$];

    ac97_cmd_sched #(.TIMEOUT_FRAMES(4)) dut (
        .ac97_bitclk(clk), .ac97_rst_b(rst_b), .ac97_strobe(strobe),
        .ac97_in_tag(in_tag), .ac97_in_slot1(in_slot1), .ac97_in_slot2(in_slot2),
        .ac97_out_slot1(out_slot1), .ac97_out_slot1_valid(out_slot1_v),
        .ac97_out_slot2(out_slot2), .ac97_out_slot2_valid(out_slot2_v),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .done0(done0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .done1(done1), .rdata1(rdata1), .err1(err1)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // fcnt is bumped as each strobe is raised, so it names the strobe a done belongs to.
    task automatic frame();
        @(negedge clk);
        strobe = 1'b1;
        fcnt++;
        @(negedge clk);
        strobe = 1'b0;
        repeat (FR - 2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic expect_done(input bit id, input logic [15:0] rd, input bit err, input bit chk_rd, input int fr);
        exp_t e;
        e.id = id; e.rd = rd; e.err = err; e.chk_rd = chk_rd; e.fr = fr;
        q.push_back(e);
    endtask

    task automatic check_slots(input string tag, input logic [19:0] s1, input logic v1, input logic [19:0] s2, input logic v2);
        check({tag, "_s1"}, out_slot1, s1);
        check({tag, "_v1"}, out_slot1_v, v1);
        check({tag, "_s2"}, out_slot2, s2);
        check({tag, "_v2"}, out_slot2_v, v2);
    endtask

    always @(negedge clk) begin
        if (rst_b && (done0 || done1)) begin
            exp_t e;
            check("done_excl", done0 & done1, 1'b0);
            check("sb_nonempty", q.size() != 0, 1'b1);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("done_id", done1, e.id);
                check("done_frame", fcnt, e.fr);
                check("done_err", e.id ? err1 : err0, e.err);
                if (e.chk_rd) check("done_rdata", e.id ? rdata1 : rdata0, e.rd);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        check_slots("rst", 20'h0, 0, 20'h0, 0);
        check("rst_done", {done1, done0}, 2'b00);
        check("rst_rdata", {rdata1, rdata0}, 32'h0);
        check("rst_err", {err1, err0}, 2'b00);
        rst_b = 1'b1;

        // write from requester 0
        req0 = 1; we0 = 1; addr0 = 7'h02; wdata0 = 16'h1F1F;
        expect_done(0, 16'h0, 0, 0, fcnt + 2);
        frame();
        check_slots("wr", 20'h02000, 1, 20'h1F1F0, 1);
        req0 = 0;
        frame();
        check_slots("wr_idle", 20'h0, 0, 20'h0, 0);

        // read from requester 1, echoed in the second frame after issue
        req1 = 1; we1 = 0; addr1 = 7'h26;
        expect_done(1, 16'h000F, 0, 1, fcnt + 3);
        frame();
        check_slots("rd", 20'hA6000, 1, 20'h0, 0);
        req1 = 0;
        frame();
        in_tag = 16'h6000; in_slot1 = 20'h26000; in_slot2 = 20'h000F0;
        frame();
        in_tag = '0; in_slot1 = '0; in_slot2 = '0;

        // read timeout with a wrong-address echo and a partial-tag echo
        req0 = 1; we0 = 0; addr0 = 7'h7C;
        expect_done(0, 16'hFFFF, 1, 1, fcnt + 6);
        frame();
        check_slots("to", 20'hFC000, 1, 20'h0, 0);
        req0 = 0;
        frame();
        in_tag = 16'h6000; in_slot1 = 20'h7B000; in_slot2 = 20'h12340;
        frame();
        in_tag = 16'h4000; in_slot1 = 20'h7C000;
        frame();
        in_tag = '0; in_slot1 = '0; in_slot2 = '0;
        repeat (2) frame();

        // request dropped before any strobe is never granted
        req0 = 1;
        repeat (3) @(negedge clk);
        req0 = 0;
        frame();
        check("cancel_v1", out_slot1_v, 1'b0);

        // reset in WAIT_RD loses the transaction
        req1 = 1; we1 = 0; addr1 = 7'h33;
        frame();
        req1 = 0;
        repeat (2) frame();
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("mid_rst_rdata1", rdata1, 16'h0);
        check("mid_rst_err0", err0, 1'b0);
        check("mid_rst_v", {out_slot1_v, out_slot2_v}, 2'b00);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        repeat (6) frame();
        req1 = 1; we1 = 1; addr1 = 7'h05; wdata1 = 16'hABCD;
        expect_done(1, 16'h0, 0, 0, fcnt + 2);
        frame();
        check_slots("post_rst", 20'h05000, 1, 20'hABCD0, 1);
        req1 = 0;
        frame();

        // contention after reset alternates 0,1,0,1
        do_reset();
        req0 = 1; we0 = 1; addr0 = 7'h10; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 7'h20; wdata1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            expect_done(i[0], 16'h0, 0, 0, fcnt + 2);
            frame();
            check("rr_slot1", out_slot1, i[0] ? 20'h20000 : 20'h10000);
            frame();
        end
        req0 = 0; req1 = 0;
        repeat (2) frame();
        check("sb_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
